reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 10 +
 rtl/reg_scoreboard_if.sv | 34 +++
 rtl/reg_scoreboard_sb_match.sv | 17 +
 rtl/reg_scoreboard.sv | 98 +++++++++
 tb/tb_reg_scoreboard.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned MAX_OUT_DEF = 4;
  // Counter must represent 0..MAX_OUT inclusive
  localparam int unsigned CNT_W       = $clog2(MAX_OUT_DEF + 1);

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID-stage / writeback / status bundle between the pipeline and the scoreboard.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_long;
  logic                  flush;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  stall;
  logic [NUM_REGS-1:0]   busy;
  logic [CNT_W-1:0]      out_cnt;
  logic                  sb_err;

  // Pipeline side
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_long, flush, wb_valid, wb_rd,
    input  stall, busy, out_cnt, sb_err
  );

  // Scoreboard side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_long, flush, wb_valid, wb_rd,
    output stall, busy, out_cnt, sb_err
  );
endinterface

// File: rtl/reg_scoreboard_sb_match.sv
// Busy-and-not-bypassed test for a single register address.
module sb_match
  import reg_scoreboard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [NUM_REGS-1:0]   busy,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  hit_c
);

  // x0 is never pending; a same-cycle writeback is forwarded, so not a hit
  always_comb begin
    hit_c = (addr != '0) & busy[addr] & ~(wb_valid & (wb_rd == addr));
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending long-latency writes and stalls ID on
// RAW, WAW and capacity hazards.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  reg_scoreboard_if.slave sb
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                sb_err_q, sb_err_d;

  logic hit_rs1_c, hit_rs2_c, hit_rd_c;
  logic hz_src_c, hz_waw_c, hz_cap_c;
  logic stall_c, issue_c, long_issue_c, set_c, clr_c;

  sb_match u_match_rs1 (
    .addr     (sb.id_rs1),
    .busy     (busy_q),
    .wb_valid (sb.wb_valid),
    .wb_rd    (sb.wb_rd),
    .hit_c    (hit_rs1_c)
  );

  sb_match u_match_rs2 (
    .addr     (sb.id_rs2),
    .busy     (busy_q),
    .wb_valid (sb.wb_valid),
    .wb_rd    (sb.wb_rd),
    .hit_c    (hit_rs2_c)
  );

  sb_match u_match_rd (
    .addr     (sb.id_rd),
    .busy     (busy_q),
    .wb_valid (sb.wb_valid),
    .wb_rd    (sb.wb_rd),
    .hit_c    (hit_rd_c)
  );

  // Hazard detection, stall and issue qualification
  always_comb begin
    hz_src_c     = (sb.id_use_rs1 & hit_rs1_c) | (sb.id_use_rs2 & hit_rs2_c);
    hz_waw_c     = sb.id_reg_write & hit_rd_c;
    hz_cap_c     = sb.id_long & sb.id_reg_write &
                   (out_cnt_q == CNT_W'(MAX_OUT)) & ~sb.wb_valid;
    stall_c      = ~rst & sb.id_valid & ~sb.flush & (hz_src_c | hz_waw_c | hz_cap_c);
    issue_c      = sb.id_valid & ~stall_c & ~sb.flush;
    long_issue_c = issue_c & sb.id_reg_write & sb.id_long;
    set_c        = long_issue_c & (sb.id_rd != '0);
    clr_c        = sb.wb_valid & (sb.wb_rd != '0);
  end

  // Next-state for busy bits, outstanding counter and sticky error
  always_comb begin
    busy_d    = busy_q;
    out_cnt_d = out_cnt_q;
    sb_err_d  = sb_err_q;

    // Clear first so a same-register set in the same cycle wins
    if (clr_c) begin
      busy_d[sb.wb_rd] = 1'b0;
      if (!busy_q[sb.wb_rd]) sb_err_d = 1'b1;
    end
    if (set_c) busy_d[sb.id_rd] = 1'b1;
    busy_d[0] = 1'b0;

    if (long_issue_c && !sb.wb_valid) begin
      if (out_cnt_q != CNT_W'(MAX_OUT)) out_cnt_d = out_cnt_q + CNT_W'(1);
    end else if (sb.wb_valid && !long_issue_c) begin
      if (out_cnt_q == '0) sb_err_d  = 1'b1;
      else                 out_cnt_d = out_cnt_q - CNT_W'(1);
    end
  end

  // All scoreboard state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      out_cnt_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      out_cnt_q <= out_cnt_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign sb.stall   = stall_c;
  assign sb.busy    = busy_q;
  assign sb.out_cnt = out_cnt_q;
  assign sb.sb_err  = sb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  reg_scoreboard_if sb_if ();

  reg_scoreboard #(.MAX_OUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.id_valid     = 1'b0;
    sb_if.id_rs1       = '0;
    sb_if.id_rs2       = '0;
    sb_if.id_use_rs1   = 1'b0;
    sb_if.id_use_rs2   = 1'b0;
    sb_if.id_rd        = '0;
    sb_if.id_reg_write = 1'b0;
    sb_if.id_long      = 1'b0;
    sb_if.flush        = 1'b0;
    sb_if.wb_valid     = 1'b0;
    sb_if.wb_rd        = '0;
  endtask

  task automatic id_long_wr(input logic [4:0] rd);
    sb_if.id_valid     = 1'b1;
    sb_if.id_rd        = rd;
    sb_if.id_reg_write = 1'b1;
    sb_if.id_long      = 1'b1;
  endtask

  task automatic wb(input logic [4:0] rd);
    sb_if.wb_valid = 1'b1;
    sb_if.wb_rd    = rd;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    rst = 1'b1;
    wb(5'd3);
    step();
    step();
    #1;
    check_eq("rst_stall", 32'(sb_if.stall), 32'd0);
    check_eq("rst_busy", sb_if.busy, 32'd0);
    check_eq("rst_cnt", 32'(sb_if.out_cnt), 32'd0);
    check_eq("rst_err", 32'(sb_if.sb_err), 32'd0);
    idle();
    rst = 1'b0;
    step();

    // RAW stall on a pending long write
    id_long_wr(5'd5);
    #1 check_eq("issue5_stall", 32'(sb_if.stall), 32'd0);
    step();
    check_eq("issue5_busy", sb_if.busy, 32'h0000_0020);
    check_eq("issue5_cnt", 32'(sb_if.out_cnt), 32'd1);
    idle();
    sb_if.id_valid = 1'b1; sb_if.id_rs1 = 5'd5; sb_if.id_use_rs1 = 1'b1;
    sb_if.id_rd = 5'd10; sb_if.id_reg_write = 1'b1;
    #1 check_eq("raw_rs1_stall", 32'(sb_if.stall), 32'd1);
    step();
    check_eq("raw_busy_hold", sb_if.busy, 32'h0000_0020);
    check_eq("raw_cnt_hold", 32'(sb_if.out_cnt), 32'd1);

    // Writeback bypass on rs2
    idle();
    sb_if.id_valid = 1'b1; sb_if.id_rs2 = 5'd5; sb_if.id_use_rs2 = 1'b1;
    wb(5'd5);
    #1 check_eq("bypass_stall", 32'(sb_if.stall), 32'd0);
    step();
    check_eq("bypass_busy", sb_if.busy, 32'd0);
    check_eq("bypass_cnt", 32'(sb_if.out_cnt), 32'd0);
    check_eq("bypass_err", 32'(sb_if.sb_err), 32'd0);

    // Capacity limit
    for (int r = 1; r <= 4; r++) begin
      idle();
      id_long_wr(5'(r));
      step();
    end
    check_eq("cap_busy4", sb_if.busy, 32'h0000_001E);
    check_eq("cap_cnt4", 32'(sb_if.out_cnt), 32'd4);
    idle();
    id_long_wr(5'd6);
    #1 check_eq("cap_stall", 32'(sb_if.stall), 32'd1);
    step();
    check_eq("cap_cnt_sat", 32'(sb_if.out_cnt), 32'd4);
    check_eq("cap_no_set6", sb_if.busy, 32'h0000_001E);
    wb(5'd1);
    #1 check_eq("cap_wb_stall", 32'(sb_if.stall), 32'd0);
    step();
    check_eq("cap_wb_cnt", 32'(sb_if.out_cnt), 32'd4);
    check_eq("cap_wb_busy", sb_if.busy, 32'h0000_005C);
    idle();
    wb(5'd2); step();
    wb(5'd3); step();
    wb(5'd4); step();
    wb(5'd6); step();
    check_eq("drain_busy", sb_if.busy, 32'd0);
    check_eq("drain_cnt", 32'(sb_if.out_cnt), 32'd0);
    check_eq("drain_err", 32'(sb_if.sb_err), 32'd0);

    // Set wins over clear on the same register
    idle();
    id_long_wr(5'd7);
    step();
    wb(5'd7);
    #1 check_eq("waw_bypass_stall", 32'(sb_if.stall), 32'd0);
    step();
    check_eq("setwin_busy", sb_if.busy, 32'h0000_0080);
    check_eq("setwin_cnt", 32'(sb_if.out_cnt), 32'd1);
    idle();
    id_long_wr(5'd7);
    #1 check_eq("waw_stall", 32'(sb_if.stall), 32'd1);
    idle();
    wb(5'd7);
    step();
    check_eq("clr7_busy", sb_if.busy, 32'd0);
    check_eq("clr7_cnt", 32'(sb_if.out_cnt), 32'd0);

    // Flush squashes issue
    idle();
    id_long_wr(5'd8);
    sb_if.flush = 1'b1;
    #1 check_eq("flush_stall", 32'(sb_if.stall), 32'd0);
    step();
    check_eq("flush_busy", sb_if.busy, 32'd0);
    check_eq("flush_cnt", 32'(sb_if.out_cnt), 32'd0);

    // Spurious writeback sets sticky error; reset clears everything
    idle();
    wb(5'd9);
    step();
    idle();
    check_eq("err_set", 32'(sb_if.sb_err), 32'd1);
    check_eq("err_cnt_floor", 32'(sb_if.out_cnt), 32'd0);
    step();
    check_eq("err_sticky", 32'(sb_if.sb_err), 32'd1);
    id_long_wr(5'd12);
    step();
    check_eq("pre_rst_busy", sb_if.busy, 32'h0000_1000);
    idle();
    rst = 1'b1;
    sb_if.id_valid = 1'b1; sb_if.id_rs1 = 5'd12; sb_if.id_use_rs1 = 1'b1;
    wb(5'd12);
    #1 check_eq("rst_force_stall", 32'(sb_if.stall), 32'd0);
    step();
    check_eq("rst2_err", 32'(sb_if.sb_err), 32'd0);
    check_eq("rst2_busy", sb_if.busy, 32'd0);
    check_eq("rst2_cnt", 32'(sb_if.out_cnt), 32'd0);
    idle();
    rst = 1'b0;
    step();

    // Fill every busy bit, then x0 operands must never stall
    for (int r = 1; r < 32; r++) begin
      idle();
      id_long_wr(5'(r));
      wb(5'd0);
      step();
    end
    idle();
    check_eq("fill_busy", sb_if.busy, 32'hFFFF_FFFE);
    check_eq("fill_cnt", 32'(sb_if.out_cnt), 32'd0);
    check_eq("fill_err", 32'(sb_if.sb_err), 32'd0);
    sb_if.id_valid = 1'b1; sb_if.id_rs1 = 5'd0; sb_if.id_use_rs1 = 1'b1;
    sb_if.id_rd = 5'd0; sb_if.id_reg_write = 1'b1; sb_if.id_long = 1'b1;
    #1 check_eq("x0_stall", 32'(sb_if.stall), 32'd0);
    step();
    check_eq("x0_busy0", 32'(sb_if.busy[0]), 32'd0);
    check_eq("x0_cnt", 32'(sb_if.out_cnt), 32'd1);
    idle();
    sb_if.id_valid = 1'b1; sb_if.id_rs2 = 5'd17; sb_if.id_use_rs2 = 1'b1;
    #1 check_eq("full_rs2_stall", 32'(sb_if.stall), 32'd1);

    // Decrement below zero flags an error
    idle();
    wb(5'd0); step();
    check_eq("dec_cnt0", 32'(sb_if.out_cnt), 32'd0);
    check_eq("dec_err_clear", 32'(sb_if.sb_err), 32'd0);
    wb(5'd0); step();
    idle();
    check_eq("dec_err_set", 32'(sb_if.sb_err), 32'd1);
    check_eq("dec_cnt_floor", 32'(sb_if.out_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
